// File: rtl/rr_arbiter_param.sv
// N-way round-robin arbiter with registered one-hot grant, explicit release
// and a bounded tenure while other masters are waiting.
module rr_arbiter_param #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N-1:0]                      req,
  input  logic                              done,
  output logic [N-1:0]                      gnt,
  output logic [(N > 1 ? $clog2(N) : 1)-1:0] gnt_id,
  output logic                              gnt_valid
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_ONE = HCW'(1);

  logic [0:0]     state_reg, state_next;
  logic [N-1:0]   gnt_reg, gnt_next;
  logic [IDW-1:0] id_reg, id_next;
  logic [IDW-1:0] last_reg, last_next;
  logic [HCW-1:0] hold_reg, hold_next;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic           owner_req;
  logic           others_pending;
  logic           timeout;
  logic           release_grant;
  logic [N-1:0]   other_req;

  // Scan from last+1 upward with wrap; iterating downward lets the
  // closest-to-start requester overwrite the others.
  always_comb begin
    int pos;
    win_found = 1'b0;
    win_idx   = '0;
    pos       = 0;
    for (int j = N - 1; j >= 0; j--) begin
      pos = int'(last_reg) + 1 + j;
      if (pos >= N) pos = pos - N;
      if (req[pos]) begin
        win_found = 1'b1;
        win_idx   = IDW'(pos);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_other
      assign other_req[gi] = req[gi] & ~gnt_reg[gi];
    end
  endgenerate

  assign owner_req      = |(req & gnt_reg);
  assign others_pending = |other_req;
  assign timeout        = (MAX_HOLD != 0) && (hold_reg == HOLD_MAX) && others_pending;
  assign release_grant  = done || !owner_req || timeout;

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    id_next    = id_reg;
    last_next  = last_reg;
    hold_next  = hold_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next = GRANT;
          gnt_next   = N'(1) << win_idx;
          id_next    = win_idx;
          last_next  = win_idx;
          hold_next  = HOLD_ONE;
        end
      end
      default: begin
        if (!release_grant) begin
          if (hold_reg < HOLD_MAX) hold_next = hold_reg + HOLD_ONE;
        end else if (win_found) begin
          // Handover without an idle bubble; may re-grant the same owner.
          gnt_next  = N'(1) << win_idx;
          id_next   = win_idx;
          last_next = win_idx;
          hold_next = HOLD_ONE;
        end else begin
          state_next = IDLE;
          gnt_next   = '0;
          id_next    = '0;
          hold_next  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      id_reg    <= '0;
      last_reg  <= IDW'(N - 1);
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      id_reg    <= id_next;
      last_reg  <= last_next;
      hold_reg  <= hold_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_id    = id_reg;
  assign gnt_valid = |gnt_reg;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Directed bench for rr_arbiter_param (N=4, MAX_HOLD=4); inputs change on
// the falling edge and outputs are checked on the following falling edge.
module tb_rr_arbiter_param;

  localparam int N = 4;
  localparam int MAX_HOLD = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         gnt_valid;

  int checks = 0;
  int errors = 0;

  rr_arbiter_param #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .done(done),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .gnt_valid(gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      $display("pass %s: %0h at %0t", tag, got, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_id,
                           input logic exp_valid);
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ".id"}, 32'(gnt_id), 32'(exp_id));
    check({tag, ".valid"}, 32'(gnt_valid), 32'(exp_valid));
  endtask

  initial begin
    logic [3:0] exp_g;
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    repeat (2) tick;
    check_all("reset", 4'b0000, 2'd0, 1'b0);

    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      check_all("idle", 4'b0000, 2'd0, 1'b0);
    end

    // Rotation: done pulsed on every grant cycle
    req = 4'b1111;
    tick;
    check_all("rot0", 4'b0001, 2'd0, 1'b1);
    done = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick;
      exp_g = 4'b0001 << (k % 4);
      check_all($sformatf("rot%0d", k), exp_g, 2'(k % 4), 1'b1);
    end
    done = 1'b0;
    req  = 4'b0000;
    tick;
    check_all("rot_idle", 4'b0000, 2'd0, 1'b0);

    // Timeout: last owner was 1, so 0 wins first
    req = 4'b0011;
    for (int k = 0; k < 10; k++) begin
      tick;
      exp_g = (k >= 4 && k < 8) ? 4'b0010 : 4'b0001;
      check($sformatf("tmo%0d", k), 32'(gnt), 32'(exp_g));
    end
    req = 4'b0000;
    tick;
    check_all("tmo_idle", 4'b0000, 2'd0, 1'b0);

    // Lone requester never times out
    req = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      tick;
      check($sformatf("lone%0d", k), 32'(gnt), 32'h4);
    end

    // Request drop and wrap
    req = 4'b1001;
    tick;
    check_all("drop3", 4'b1000, 2'd3, 1'b1);
    req = 4'b0001;
    tick;
    check_all("wrap0", 4'b0001, 2'd0, 1'b1);
    req = 4'b0010;
    tick;
    check_all("drop1", 4'b0010, 2'd1, 1'b1);
    done = 1'b1;
    tick;
    check_all("done_regrant", 4'b0010, 2'd1, 1'b1);
    done = 1'b0;
    req  = 4'b0000;
    tick;
    check_all("drop_idle", 4'b0000, 2'd0, 1'b0);
    done = 1'b1;
    tick;
    check_all("done_idle", 4'b0000, 2'd0, 1'b0);
    done = 1'b0;

    // Async reset mid-grant
    req = 4'b0100;
    tick;
    check_all("pre_rst", 4'b0100, 2'd2, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 4'b0000, 2'd0, 1'b0);
    tick;
    rst_n = 1'b1;
    req   = 4'b1111;
    tick;
    check_all("post_rst", 4'b0001, 2'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_param.md
# rr_arbiter_param

Parametrised N-way round-robin arbiter with grant hold, explicit release and a bounded-tenure timeout. It sits between N requesting masters and one shared resource (bus, memory port, FIFO write side). Grants are one-hot, registered and visible one cycle after the request is sampled. An owner keeps its grant until it signals `done`, drops `req`, or has used its maximum tenure while another requester waits.

## Interface
- `N`, default 4: number of requesters; must be at least 2.
- `MAX_HOLD`, default 4: maximum consecutive grant cycles for one owner while others are pending. A value of 0 disables the timeout.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  N: request vector; bit i is requester i, level-sensitive.
- `done`  in  1: current owner releases the grant; ignored when `gnt_valid`=0.
- `gnt`  out  N: one-hot grant (registered); all-zero when idle.
- `gnt_id`  out  max(1,$clog2(N)): binary index of the owner; 0 when idle.
- `gnt_valid`  out  1: high when a grant is active; equals |`gnt`.

## Operation
- **State.** The FSM has two states, IDLE and GRANT. Other state:
  - `last`: pointer to the last granted index.
  - `hold_cnt`: width $clog2(MAX_HOLD+1), saturating at MAX_HOLD.
- **Arbitration function.** Scan `req` starting at index (`last`+1) mod N, wrapping through N-1 to 0. The first set bit wins. The previous owner is therefore always lowest priority.
- **IDLE.**
  - If `req` is non-zero, go to GRANT with the winner. Load `gnt`/`gnt_id` with the winner, set `last` to the winner and set `hold_cnt` to 1.
  - Otherwise stay in IDLE with all outputs zero.
- **GRANT, owner k.** The release condition is any of:
  - (a) `done`=1
  - (b) `req[k]`=0
  - (c) MAX_HOLD≠0, `hold_cnt`==MAX_HOLD, and `req` with bit k masked is non-zero
- **GRANT, no release.** Keep k and increment `hold_cnt` (saturating).
- **GRANT, on release.** Re-arbitrate in the same cycle on the current `req`. This includes `req[k]` if it is still high, at lowest priority.
  - If there is a winner: move to GRANT with the new owner (which may be k again), `hold_cnt`=1, `last` updated. There is no idle bubble.
  - If there is no winner: go to IDLE and clear `gnt`, `gnt_id` and `gnt_valid` at the next edge.
- **Lone requester.** If k is the only requester, (c) never fires. The grant is held indefinitely and `hold_cnt` stays saturated.
- **`done` with `req[k]` still high and no other request.** k is re-granted with `hold_cnt`=1; `gnt` stays unchanged.
- **Invariant.** `gnt` is always one-hot or zero. It never grants a requester whose `req` bit was 0 at the deciding edge.

## Timing
- **Reset values.** `gnt`=0, `gnt_id`=0, `gnt_valid`=0, state=IDLE, `last`=N-1 (so requester 0 has first priority), `hold_cnt`=0.
- **Reset mid-grant.** Asserting `rst_n` low in the middle of a grant clears the outputs immediately (asynchronously), without waiting for a clock edge.
- **Latency.** `req` sampled at edge t produces `gnt` valid after edge t. The minimum request-to-grant latency is 1 cycle.
- **Tenure.** With others pending and no `done`, an owner holds the grant for exactly MAX_HOLD cycles.
- **Release to handover.** `done` or a `req[k]` drop at edge t causes the handover (or idle) after edge t. The next owner sees `gnt` in the cycle following its last old-owner cycle.
- **Simultaneous events.** `done` together with timeout, or `done` together with a `req[k]` drop, counts as a single release and re-arbitrates once.
- **Combinational paths.** There are no combinational paths from inputs to outputs.

## Test plan
- **Reset and idle.** Hold `rst_n`=0, then release with `req`=0 -> `gnt`=0000, `gnt_id`=0, `gnt_valid`=0 for 5 cycles.
- **Rotation.** N=4, `req`=1111, `done` pulsed every grant cycle -> `gnt_id` sequence 0,1,2,3,0,1 with no idle cycles.
- **Timeout.** MAX_HOLD=4, `req`=0011, `done`=0 -> `gnt`=0001 for 4 cycles, then 0010 for 4 cycles, then 0001.
- **Lone requester.** `req`=0100, `done`=0 for 12 cycles -> `gnt`=0100 throughout, with no drop at the timeout.
- **Request drop and wrap.** Owner 3 drops `req` while `req`=1001 -> owner becomes 3 then 0 (wrap). With `req`=0010, owner 1 drops `req`, then `req`=0000 -> next cycle `gnt`=0000, `gnt_valid`=0.
- **Async reset mid-grant.** `gnt`=0100; assert `rst_n` low mid-cycle -> outputs 0 before the next edge. After release with `req`=1111 -> first grant is 0001.
